pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised instruction-fetch front end for the OTTER core. It holds the program counter and selects the next PC from sequential, JALR, branch, jump or interrupt targets. It drives a synchronous-read instruction memory with one-cycle read latency and buffers returned words in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake, so decode stalls no longer require stalling the PC.

## Interface
- ADDR_W, 32: PC and target width in bits; ADDR_W >= 4.
- INSTR_W, 32: instruction word width.
- DEPTH, 2: fetch-queue entries; DEPTH >= 2.
- RESET_VEC, 0: PC value loaded on reset; must be 4-byte aligned.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FETCH_EN  in  1  when 0, no new memory reads are issued; in-flight data still lands.
- REDIRECT  in  1  one-cycle strobe: load the target chosen by PC_SEL.
- PC_SEL  in  3  target select: 1=JALR, 2=BRANCH, 3=JUMP, 4=INTRPT; 0 and 5–7 make REDIRECT a no-op.
- JALR, BRANCH, JUMP, INTRPT  in  ADDR_W each  redirect targets.
- IMEM_RD  out  1  read request this cycle.
- IMEM_ADDR  out  ADDR_W  byte address of the request, equal to the current PC.
- IMEM_DOUT  in  INSTR_W  read data, valid exactly one cycle after IMEM_RD.
- INSTR_VALID  out  1  the queue head is valid.
- INSTR_READY  in  1  decode accepts the head this cycle.
- INSTR  out  INSTR_W  head instruction.
- INSTR_PC  out  ADDR_W  address of the head instruction.
- MISALIGN_ERR  out  1  one-cycle pulse on a misaligned redirect; see Configuration.

## Operation
- **State:**
  - PC register.
  - `pend` flag: a read was issued last cycle.
  - `pend_pc`: address of that read.
  - `drop` flag: discard the pending response.
  - Circular queue of {pc, instr} with count 0..DEPTH.
- **Pop:** pop = INSTR_VALID && INSTR_READY.
- **Issue:**
  - Condition: FETCH_EN && !REDIRECT && (count + pend − pop) < DEPTH.
  - Action: IMEM_RD=1, IMEM_ADDR=PC, pend_pc <= PC, PC <= PC + 4 (mod 2^ADDR_W, so wrap at all-ones is legal).
- **Response:**
  - Condition: pend && !drop && !REDIRECT.
  - Action: push {pend_pc, IMEM_DOUT}.
  - The issue rule guarantees a push never overflows.
- **Simultaneous pop and push:** count is unchanged.
- **Redirect** (PC_SEL in 1..4):
  - Queue is cleared.
  - Any pending response is dropped.
  - No read is issued this cycle.
  - PC <= selected target.
  - pop and push are suppressed; INSTR_VALID is forced 0 in the redirect cycle.
- **Reserved PC_SEL with REDIRECT:** no effect at all.
- **INSTR_VALID** = (count != 0) && !REDIRECT. INSTR and INSTR_PC come from the queue head.
- **Reset (RST_N low, any time, including mid-fetch):**
  - PC = RESET_VEC.
  - count = 0, pend = 0, drop = 0.
  - IMEM_RD = 0, INSTR_VALID = 0, MISALIGN_ERR = 0.
  - Any in-flight response is ignored.

## Timing
- Reset release:
  - First edge with RST_N high ends cycle 0.
  - IMEM_RD=1 in cycle 0 with IMEM_ADDR=RESET_VEC.
  - Data returns in cycle 1 and is pushed at the end of cycle 1.
  - INSTR_VALID=1 in cycle 2.
- Redirect in cycle N:
  - Read of the target in cycle N+1.
  - INSTR_VALID with INSTR_PC=target in cycle N+3 (redirect penalty of 3 cycles).
- Steady state with INSTR_READY held 1: one instruction per cycle, no bubbles, for DEPTH >= 2.
- INSTR_READY=0: the queue fills to DEPTH and IMEM_RD falls. After ready returns, IMEM_RD reasserts in the same cycle as the first pop.
- FETCH_EN deassert: the pending word is still pushed; the PC holds its value.

## Configuration
- **Macro PC_FETCH_MISALIGN_EN defined:**
  - A redirect target with bits [1:0] != 0 is not taken.
  - PC <= INTRPT instead.
  - MISALIGN_ERR=1 for exactly the redirect cycle.
  - All other redirect effects (flush, drop, no issue) still apply.
- **Macro not defined:**
  - Target bits [1:0] are forced to 0.
  - MISALIGN_ERR is tied to 0.

## Test plan
- **Reset fetch:** RESET_VEC=0x100, INSTR_READY=1 after reset release, memory returns (addr>>2) -> INSTR_PC sequence 0x100, 0x104, 0x108, … one per cycle from cycle 2; INSTR=0x40, 0x41, ….
- **Backpressure:** DEPTH=2, hold INSTR_READY=0 for 6 cycles -> count saturates at 2 and IMEM_RD=0 once full; after release, INSTR_PC continues with no skipped or duplicated address.
- **Redirect flush:** REDIRECT with PC_SEL=3, JUMP=0x2000 while the queue is full and a read is pending -> INSTR_VALID=0 in cycles N..N+2; INSTR_PC=0x2000 in N+3; the pending word never appears.
- **Reserved select:** REDIRECT with PC_SEL=6 -> PC, queue and IMEM_RD unchanged versus a run without the strobe.
- **Wrap and reset:**
  - ADDR_W=8, start at 0xFC -> next INSTR_PC is 0x00.
  - Assert RST_N low mid-stream -> INSTR_VALID=0 immediately; refetch starts from RESET_VEC.
- **Misalign:** with PC_FETCH_MISALIGN_EN, JALR=0x202, INTRPT=0x80 -> MISALIGN_ERR pulse; fetch resumes at 0x80. Without the macro -> fetch resumes at 0x200 and MISALIGN_ERR stays 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// OTTER instruction-fetch front end: PC, redirect select, 1-cycle IMEM read, DEPTH-entry fetch queue.
// Optional misaligned-redirect trap enabled by defining PC_FETCH_MISALIGN_EN.
module pc_fetch_unit #(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        DEPTH     = 2,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               FETCH_EN,
    input  logic               REDIRECT,
    input  logic [2:0]         PC_SEL,
    input  logic [ADDR_W-1:0]  JALR,
    input  logic [ADDR_W-1:0]  BRANCH,
    input  logic [ADDR_W-1:0]  JUMP,
    input  logic [ADDR_W-1:0]  INTRPT,
    output logic               IMEM_RD,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_DOUT,
    output logic               INSTR_VALID,
    input  logic               INSTR_READY,
    output logic [INSTR_W-1:0] INSTR,
    output logic [ADDR_W-1:0]  INSTR_PC,
    output logic               MISALIGN_ERR
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pend_pc;
    logic               pend;
    logic               drop;
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               take;
    logic               misalign;
    logic               pop;
    logic               push;
    logic               issue;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  next_target;
    logic [CNT_W:0]     occupancy;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reserved PC_SEL codes never assert take, so the strobe is fully inert.
    always_comb begin
        take   = 1'b0;
        target = '0;
        case (PC_SEL)
            3'd1:    begin take = REDIRECT; target = JALR;   end
            3'd2:    begin take = REDIRECT; target = BRANCH; end
            3'd3:    begin take = REDIRECT; target = JUMP;   end
            3'd4:    begin take = REDIRECT; target = INTRPT; end
            default: begin take = 1'b0;     target = '0;     end
        endcase
`ifdef PC_FETCH_MISALIGN_EN
        misalign    = take && (target[1:0] != 2'b00);
        next_target = misalign ? INTRPT : target;
`else
        misalign    = 1'b0;
        next_target = target & ~ADDR_W'(3);
`endif
    end

    always_comb begin
        INSTR_VALID  = (count != '0) && !take;
        pop          = INSTR_VALID && INSTR_READY;
        push         = pend && !drop && !take;
        occupancy    = {1'b0, count} + (CNT_W + 1)'(pend) - (CNT_W + 1)'(pop);
        issue        = RST_N && FETCH_EN && !take && (occupancy < (CNT_W + 1)'(DEPTH));
        IMEM_RD      = issue;
        IMEM_ADDR    = pc;
        INSTR        = q_instr[head];
        INSTR_PC     = q_pc[head];
        MISALIGN_ERR = misalign && RST_N;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc      <= RESET_VEC;
            pend    <= 1'b0;
            pend_pc <= '0;
            drop    <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (take) begin
            pc    <= next_target;
            pend  <= 1'b0;
            drop  <= 1'b1;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                pc      <= pc + ADDR_W'(4);
                pend_pc <= pc;
                drop    <= 1'b0;
            end
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue payload needs no reset: count gates every read of it.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_pc[tail]    <= pend_pc;
            q_instr[tail] <= IMEM_DOUT;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random traffic against a queue-based model.
// Honours PC_FETCH_MISALIGN_EN the same way the design does.
module tb_pc_fetch_unit;

    localparam int unsigned       AW    = 16;
    localparam int unsigned       IW    = 32;
    localparam int unsigned       DEPTH = 2;
    localparam logic [AW-1:0]     RV    = 16'h0100;

    logic          CLK;
    logic          RST_N;
    logic          FETCH_EN;
    logic          REDIRECT;
    logic [2:0]    PC_SEL;
    logic [AW-1:0] JALR;
    logic [AW-1:0] BRANCH;
    logic [AW-1:0] JUMP;
    logic [AW-1:0] INTRPT;
    logic          IMEM_RD;
    logic [AW-1:0] IMEM_ADDR;
    logic [IW-1:0] IMEM_DOUT;
    logic          INSTR_VALID;
    logic          INSTR_READY;
    logic [IW-1:0] INSTR;
    logic [AW-1:0] INSTR_PC;
    logic          MISALIGN_ERR;

    pc_fetch_unit #(
        .ADDR_W    (AW),
        .INSTR_W   (IW),
        .DEPTH     (DEPTH),
        .RESET_VEC (RV)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .FETCH_EN     (FETCH_EN),
        .REDIRECT     (REDIRECT),
        .PC_SEL       (PC_SEL),
        .JALR         (JALR),
        .BRANCH       (BRANCH),
        .JUMP         (JUMP),
        .INTRPT       (INTRPT),
        .IMEM_RD      (IMEM_RD),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_DOUT    (IMEM_DOUT),
        .INSTR_VALID  (INSTR_VALID),
        .INSTR_READY  (INSTR_READY),
        .INSTR        (INSTR),
        .INSTR_PC     (INSTR_PC),
        .MISALIGN_ERR (MISALIGN_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return IW'(a >> 2);
    endfunction

    // Synchronous-read memory; non-read cycles return noise so stale data cannot pass.
    always @(posedge CLK) IMEM_DOUT <= IMEM_RD ? mem_word(IMEM_ADDR) : $urandom;

    // Reference model: a queue of fetched addresses plus one in-flight read.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_pend_pc;
    bit            m_pend;
    logic [AW-1:0] m_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend    = 0;
        m_pend_pc = '0;
        m_pc      = RV;
    endtask

    task automatic run_cycle();
        bit            take;
        bit            exp_valid;
        bit            pop;
        bit            issue;
        bit            exp_err;
        int            occ;
        logic [AW-1:0] tgt;
        logic [AW-1:0] new_pc;
        take = REDIRECT && (PC_SEL >= 3'd1) && (PC_SEL <= 3'd4);
        case (PC_SEL)
            3'd1:    tgt = JALR;
            3'd2:    tgt = BRANCH;
            3'd3:    tgt = JUMP;
            default: tgt = INTRPT;
        endcase
`ifdef PC_FETCH_MISALIGN_EN
        exp_err = take && (tgt % 4 != 0);
        new_pc  = exp_err ? INTRPT : tgt;
`else
        exp_err = 0;
        new_pc  = tgt - (tgt % 4);
`endif
        exp_valid = (m_q.size() != 0) && !take;
        pop       = exp_valid && INSTR_READY;
        occ       = m_q.size() + int'(m_pend) - int'(pop);
        issue     = FETCH_EN && !take && (occ < int'(DEPTH));

        @(negedge CLK);
        check("instr_valid", INSTR_VALID, exp_valid);
        if (exp_valid) begin
            check("instr_pc", INSTR_PC, m_q[0]);
            check("instr", INSTR, mem_word(m_q[0]));
        end
        check("imem_rd", IMEM_RD, issue);
        if (issue) check("imem_addr", IMEM_ADDR, m_pc);
        check("misalign_err", MISALIGN_ERR, exp_err);

        if (take) begin
            m_q.delete();
            m_pend = 0;
            m_pc   = new_pc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            m_pend = issue;
            if (issue) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 16'd4;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic randomize_inputs();
        FETCH_EN    = ($urandom_range(9) != 0);
        INSTR_READY = ($urandom_range(3) != 0);
        REDIRECT    = ($urandom_range(9) == 0);
        PC_SEL      = 3'($urandom_range(7));
        JALR        = AW'($urandom);
        BRANCH      = AW'($urandom);
        JUMP        = AW'($urandom);
        INTRPT      = AW'($urandom);
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_valid"}, INSTR_VALID, 1'b0);
        check({tag, "_rd"}, IMEM_RD, 1'b0);
        check({tag, "_err"}, MISALIGN_ERR, 1'b0);
    endtask

    initial begin
        RST_N       = 1'b0;
        FETCH_EN    = 1'b1;
        REDIRECT    = 1'b0;
        PC_SEL      = 3'd0;
        JALR        = '0;
        BRANCH      = '0;
        JUMP        = '0;
        INTRPT      = '0;
        INSTR_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_in_reset("por");
        model_reset();
        RST_N = 1'b1;

        // Reset fetch: 0x100, 0x104, ... streaming from cycle 2
        run(10);

        // Backpressure: queue saturates, read stalls, then resumes without gaps
        INSTR_READY = 1'b0;
        run(6);
        INSTR_READY = 1'b1;
        run(6);

        // Redirect flush with a read in flight
        REDIRECT = 1'b1; PC_SEL = 3'd3; JUMP = 16'h2000;
        run(1);
        REDIRECT = 1'b0;
        run(6);

        // Reserved selects are inert
        REDIRECT = 1'b1; PC_SEL = 3'd6; JUMP = 16'h3000; JALR = 16'h4000;
        run(1);
        PC_SEL = 3'd0;
        run(1);
        REDIRECT = 1'b0;
        run(4);

        // Address wrap through all-ones
        REDIRECT = 1'b1; PC_SEL = 3'd2; BRANCH = 16'hFFF8;
        run(1);
        REDIRECT = 1'b0;
        run(6);

        // Misaligned JALR target
        REDIRECT = 1'b1; PC_SEL = 3'd1; JALR = 16'h0202; INTRPT = 16'h0080;
        run(1);
        REDIRECT = 1'b0;
        run(6);

        // Fetch disable: in-flight word lands, PC holds
        FETCH_EN = 1'b0;
        run(4);
        INSTR_READY = 1'b0;
        run(2);
        FETCH_EN = 1'b1;
        INSTR_READY = 1'b1;
        run(5);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            run_cycle();
        end

        // Mid-stream asynchronous reset, with a misaligned redirect held
        FETCH_EN = 1'b1; INSTR_READY = 1'b1; REDIRECT = 1'b0;
        run(5);
        #3;
        RST_N    = 1'b0;
        REDIRECT = 1'b1; PC_SEL = 3'd1; JALR = 16'h0202;
        #1;
        check_in_reset("async_rst");
        @(posedge CLK);
        #1;
        check_in_reset("held_rst");
        REDIRECT = 1'b0; PC_SEL = 3'd0;
        model_reset();
        RST_N = 1'b1;
        run(8);

        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
